// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned ALIGN_BITS  = 2;

  // addi x0, x0, 0 -- presented on ir_data while nothing has been fetched
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_t;

  // A fetch target must sit on an instruction boundary
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return |addr[ALIGN_BITS-1:0];
  endfunction

endpackage : instr_fetch_unit_pkg

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: sequential increment or redirect load, load has priority.
module fetch_pc_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_inc,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_load_pc,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;

  // PC update; the add wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_inc) begin
      r_pc <= r_pc + XLEN'(INSTR_BYTES);
    end
  end

  assign o_pc = r_pc;

endmodule : fetch_pc_reg

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, single-entry
// instruction register, redirect with kill of an in-flight response and
// a sticky fault on misaligned redirect targets.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction memory
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  // instruction register
  output logic            ir_valid,
  output logic [XLEN-1:0] ir_data,
  output logic [XLEN-1:0] ir_pc,
  input  logic            ir_ready,
  // control flow
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault
);

  fetch_state_t    r_state;
  logic            r_kill;
  logic [XLEN-1:0] w_pc;
  logic            w_misalign;
  logic            w_pc_load;
  logic            w_pc_inc;

  assign w_misalign = is_misaligned(redirect_pc);

  // PC control: aligned redirects load, a consumed word advances
  always_comb begin
    w_pc_load = 1'b0;
    w_pc_inc  = 1'b0;
    if (r_state != ST_IDLE) begin
      w_pc_load = redirect && !w_misalign;
    end
    if (r_state == ST_HOLD) begin
      w_pc_inc = ir_ready && !redirect;
    end
  end

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inc     (w_pc_inc),
    .i_load    (w_pc_load),
    .i_load_pc (redirect_pc),
    .o_pc      (w_pc)
  );

  // The PC register is itself the registered fetch address
  assign mem_addr = w_pc;

  // Fetch FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_kill      <= 1'b0;
      mem_req     <= 1'b0;
      ir_valid    <= 1'b0;
      ir_data     <= NOP_INSTR;
      ir_pc       <= RESET_PC;
      fetch_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_REQ;
          mem_req <= 1'b1;
        end

        ST_REQ: begin
          if (redirect) begin
            // A grant in the redirect cycle leaves a response in flight;
            // it must be drained and discarded before the next request.
            if (mem_gnt) begin
              r_kill <= 1'b1;
            end
            if (w_misalign) begin
              r_state     <= ST_FAULT;
              mem_req     <= 1'b0;
              fetch_fault <= 1'b1;
            end else if (mem_gnt) begin
              r_state <= ST_WAIT;
              mem_req <= 1'b0;
            end else begin
              mem_req <= 1'b1;
            end
          end else if (mem_gnt) begin
            r_state <= ST_WAIT;
            mem_req <= 1'b0;
          end
        end

        ST_WAIT: begin
          if (redirect) begin
            if (w_misalign) begin
              r_state     <= ST_FAULT;
              fetch_fault <= 1'b1;
              r_kill      <= !mem_rvalid;
            end else if (mem_rvalid) begin
              // The response arriving now belongs to the old stream
              r_state <= ST_REQ;
              mem_req <= 1'b1;
              r_kill  <= 1'b0;
            end else begin
              r_kill <= 1'b1;
            end
          end else if (mem_rvalid) begin
            r_kill <= 1'b0;
            if (r_kill) begin
              r_state <= ST_REQ;
              mem_req <= 1'b1;
            end else begin
              r_state  <= ST_HOLD;
              ir_valid <= 1'b1;
              ir_data  <= mem_rdata;
              ir_pc    <= w_pc;
            end
          end
        end

        ST_HOLD: begin
          if (redirect) begin
            ir_valid <= 1'b0;
            if (w_misalign) begin
              r_state     <= ST_FAULT;
              fetch_fault <= 1'b1;
            end else begin
              r_state <= ST_REQ;
              mem_req <= 1'b1;
            end
          end else if (ir_ready) begin
            ir_valid <= 1'b0;
            r_state  <= ST_REQ;
            mem_req  <= 1'b1;
          end
        end

        ST_FAULT: begin
          // Keep tracking a response still owed from before the fault
          if (mem_rvalid) begin
            r_kill <= 1'b0;
          end
          if (redirect && !w_misalign) begin
            fetch_fault <= 1'b0;
            if (r_kill && !mem_rvalid) begin
              r_state <= ST_WAIT;
            end else begin
              r_state <= ST_REQ;
              mem_req <= 1'b1;
              r_kill  <= 1'b0;
            end
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_kill      <= 1'b0;
          mem_req     <= 1'b0;
          ir_valid    <= 1'b0;
          fetch_fault <= 1'b0;
        end
      endcase
    end
  end

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected request addresses and
// instruction words are queued by the stimulus, popped by a monitor.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        ir_valid;
  logic [31:0] ir_data;
  logic [31:0] ir_pc;
  logic        ir_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] q_addr[$];
  logic [63:0] q_ir[$];

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .ir_valid    (ir_valid),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_fault (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every granted request and every consumed word
  initial begin
    logic [31:0] ea;
    logic [63:0] ei;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (mem_req && mem_gnt) begin
          if (q_addr.size() == 0) begin
            chk1("unexpected_req", 1'b1, 1'b0);
          end else begin
            ea = q_addr.pop_front();
            chk32("sb_mem_addr", mem_addr, ea);
          end
        end
        if (ir_valid && ir_ready) begin
          if (q_ir.size() == 0) begin
            chk1("unexpected_ir", 1'b1, 1'b0);
          end else begin
            ei = q_ir.pop_front();
            chk32("sb_ir_pc", ir_pc, ei[63:32]);
            chk32("sb_ir_data", ir_data, ei[31:0]);
          end
        end
      end
    end
  end

  // One fetch: optional grant delay, immediate response, optional stall
  task automatic fetch_one(input logic [31:0] a, input logic [31:0] d,
                           input int gnt_dly, input int rdy_dly, input bit consume);
    int t;
    t = 0;
    q_addr.push_back(a);
    if (consume) q_ir.push_back({a, d});
    while (!mem_req && t < 20) begin
      step();
      t++;
    end
    chk1("req_seen", mem_req, 1'b1);
    chk32("req_addr", mem_addr, a);
    repeat (gnt_dly) begin
      step();
      chk1("req_held", mem_req, 1'b1);
      chk32("addr_stable", mem_addr, a);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk1("req_drop", mem_req, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    chk1("ir_valid_up", ir_valid, 1'b1);
    chk32("ir_pc", ir_pc, a);
    chk32("ir_data", ir_data, d);
    repeat (rdy_dly) begin
      step();
      chk1("ir_valid_stall", ir_valid, 1'b1);
      chk32("ir_data_stable", ir_data, d);
    end
    if (consume) begin
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0;
      chk1("ir_valid_down", ir_valid, 1'b0);
    end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    ir_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) step();

    // Reset values
    chk1("rst_mem_req", mem_req, 1'b0);
    chk32("rst_mem_addr", mem_addr, RST_PC);
    chk1("rst_ir_valid", ir_valid, 1'b0);
    chk32("rst_ir_data", ir_data, NOP);
    chk32("rst_ir_pc", ir_pc, RST_PC);
    chk1("rst_fault", fetch_fault, 1'b0);

    // First fetch, gnt and rvalid held high from release: ir_valid in cycle 3
    q_addr.push_back(RST_PC);
    q_ir.push_back({RST_PC, 32'h0050_0093});
    rst_n      = 1'b1;
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0050_0093;
    step();
    chk1("c1_req", mem_req, 1'b1);
    chk1("c1_ir_valid", ir_valid, 1'b0);
    step();
    mem_gnt = 1'b0;
    chk1("c2_req", mem_req, 1'b0);
    chk1("c2_ir_valid", ir_valid, 1'b0);
    step();
    mem_rvalid = 1'b0;
    chk1("c3_ir_valid", ir_valid, 1'b1);
    chk32("c3_ir_pc", ir_pc, 32'h0000_1000);
    chk32("c3_ir_data", ir_data, 32'h0050_0093);
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    chk1("b2b_req", mem_req, 1'b1);
    chk32("b2b_addr", mem_addr, 32'h0000_1004);

    // Back-to-back fetches
    fetch_one(32'h0000_1004, 32'h00A0_0113, 0, 0, 1'b1);
    chk32("b2b_addr2", mem_addr, 32'h0000_1008);
    fetch_one(32'h0000_1008, 32'h00F0_0193, 0, 0, 1'b1);
    fetch_one(32'h0000_100C, 32'h0140_0213, 0, 0, 1'b1);

    // Grant withheld 5 cycles, consumer stalls 4 cycles
    fetch_one(32'h0000_1010, 32'h0020_81B3, 5, 4, 1'b1);

    // Two redirects while a response is outstanding; last one wins
    q_addr.push_back(32'h0000_1014);
    chk32("pre_kill_addr", mem_addr, 32'h0000_1014);
    mem_gnt = 1'b1;
    step();
    mem_gnt     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2100;
    step();
    redirect_pc = 32'h0000_2000;
    step();
    redirect = 1'b0;
    chk1("kill_wait_req", mem_req, 1'b0);
    chk1("kill_wait_irv", ir_valid, 1'b0);
    step();
    chk1("kill_wait_irv2", ir_valid, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    chk1("stale_irv", ir_valid, 1'b0);
    chk1("stale_req", mem_req, 1'b1);
    chk32("stale_next_addr", mem_addr, 32'h0000_2000);
    step();
    chk1("stale_irv2", ir_valid, 1'b0);
    fetch_one(32'h0000_2000, 32'h0000_0517, 0, 0, 1'b1);

    // Redirect together with ir_ready: word consumed, redirect target wins
    fetch_one(32'h0000_2004, 32'h0040_0593, 0, 0, 1'b0);
    q_ir.push_back({32'h0000_2004, 32'h0040_0593});
    ir_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2400;
    step();
    ir_ready = 1'b0;
    redirect = 1'b0;
    chk1("rdr_rdy_irv", ir_valid, 1'b0);
    chk1("rdr_rdy_req", mem_req, 1'b1);
    chk32("rdr_rdy_addr", mem_addr, 32'h0000_2400);

    // Misaligned redirect halts fetching until an aligned one
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2002;
    step();
    redirect = 1'b0;
    chk1("fault_set", fetch_fault, 1'b1);
    chk1("fault_req", mem_req, 1'b0);
    chk1("fault_irv", ir_valid, 1'b0);
    mem_rvalid = 1'b1;
    repeat (3) begin
      step();
      chk1("fault_hold", fetch_fault, 1'b1);
      chk1("fault_hold_req", mem_req, 1'b0);
      chk1("fault_hold_irv", ir_valid, 1'b0);
    end
    mem_rvalid  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3000;
    step();
    redirect = 1'b0;
    chk1("fault_clear", fetch_fault, 1'b0);
    chk1("fault_exit_req", mem_req, 1'b1);
    chk32("fault_exit_addr", mem_addr, 32'h0000_3000);
    fetch_one(32'h0000_3000, 32'h0010_0073, 0, 0, 1'b1);

    // PC wraps from the top of the address space to zero
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'h0000_006F, 0, 0, 1'b1);
    chk1("wrap_req", mem_req, 1'b1);
    chk32("wrap_addr", mem_addr, 32'h0000_0000);

    // Reset pulsed in WAIT: immediate reset values, late response ignored
    q_addr.push_back(32'h0000_0000);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk1("arst_req", mem_req, 1'b0);
    chk32("arst_addr", mem_addr, RST_PC);
    chk1("arst_irv", ir_valid, 1'b0);
    chk32("arst_ir_data", ir_data, NOP);
    chk32("arst_ir_pc", ir_pc, RST_PC);
    chk1("arst_fault", fetch_fault, 1'b0);
    step();
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    step();
    chk1("post_rst_req", mem_req, 1'b1);
    chk32("post_rst_addr", mem_addr, RST_PC);
    chk1("post_rst_irv", ir_valid, 1'b0);
    step();
    mem_rvalid = 1'b0;
    chk1("post_rst_irv2", ir_valid, 1'b0);
    chk1("post_rst_req2", mem_req, 1'b1);
    fetch_one(RST_PC, 32'h0030_0313, 0, 0, 1'b1);

    repeat (2) step();
    chk32("sb_addr_empty", 32'(q_addr.size()), 32'd0);
    chk32("sb_ir_empty", 32'(q_ir.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_instr_fetch_unit

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_1000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock; the block SHALL have one clock.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 mem_req  output  1  fetch request to instruction memory.
REQ-005 mem_addr  output  32  fetch byte address; valid while mem_req=1.
REQ-006 mem_gnt  input  1  memory accepts the request this cycle when mem_req=1.
REQ-007 mem_rvalid  input  1  read data valid this cycle.
REQ-008 mem_rdata  input  32  instruction word returned by memory.
REQ-009 ir_valid  output  1  instruction word available to the instruction register.
REQ-010 ir_data  output  32  instruction word; stable while ir_valid=1.
REQ-011 ir_pc  output  32  address of ir_data.
REQ-012 ir_ready  input  1  consumer takes ir_data this cycle when ir_valid=1.
REQ-013 redirect  input  1  branch/jump: abandon the current fetch and restart at redirect_pc.
REQ-014 redirect_pc  input  32  new fetch address.
REQ-015 fetch_fault  output  1  misaligned redirect target; fetching halted.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, WAIT, HOLD and FAULT.
REQ-017 IDLE SHALL last exactly one cycle after reset release and then go to REQ with pc=RESET_PC.
REQ-018 REQ: mem_req=1 and mem_addr=pc; held stable until mem_gnt=1; on gnt -> WAIT.
REQ-019 WAIT: mem_req=0; on mem_rvalid, ir_data<=mem_rdata and ir_pc<=pc registered; -> HOLD.
REQ-020 HOLD: ir_valid=1; on ir_ready=1, pc<=pc+4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0) -> REQ.
REQ-021 ir_valid SHALL rise the cycle after mem_rvalid; best-case grant-to-ir_valid latency is 2 cycles (gnt N, rvalid N+1, ir_valid N+2).
REQ-022 Back-to-back: HOLD handshake at cycle M SHALL put mem_req=1 with the new address at M+1.
REQ-023 mem_rvalid outside WAIT SHALL be ignored.
REQ-024 redirect in REQ or HOLD: pc<=redirect_pc; ir_valid=0 from the next cycle; -> REQ.
REQ-025 redirect in WAIT: the outstanding response SHALL be discarded through a kill flag; pc<=redirect_pc; the FSM stays in WAIT until that rvalid, then goes to REQ without asserting ir_valid.
REQ-026 redirect and ir_ready in the same cycle: redirect wins; the handshake still consumes the current word; pc<=redirect_pc, not pc+4.
REQ-027 Multiple redirects before the discarded response returns: the last redirect_pc wins.
REQ-028 redirect_pc[1:0]!=0: -> FAULT with fetch_fault=1, mem_req=0 and ir_valid=0.
REQ-029 FAULT SHALL persist until an aligned redirect, which clears fetch_fault the next cycle and goes to REQ.

Reset
REQ-030 rst_n low SHALL force, asynchronously: state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, ir_valid=0, ir_data=32'h0000_0013 (NOP), ir_pc=RESET_PC, fetch_fault=0, kill=0.
REQ-031 Reset mid-fetch SHALL abandon the fetch; a late mem_rvalid after release SHALL be ignored (IDLE/REQ).

Structure
REQ-032 A shared package SHALL hold the fetch_state_t enum, INSTR_BYTES=4 and NOP_INSTR=32'h0000_0013.
REQ-033 One sub-module, fetch_pc_reg, SHALL hold pc with increment/redirect load; everything else stays flat.

Verification
REQ-034 Reset release, gnt and rvalid immediate, mem_rdata=32'h00500093 -> ir_valid at cycle 3, ir_pc=32'h1000, ir_data=32'h00500093.
REQ-035 Three back-to-back fetches with ir_ready=1 -> mem_addr 1000, 1004, 1008; ir_pc matches each word.
REQ-036 Redirect to 32'h2000 in WAIT, stale rvalid 2 cycles later -> no ir_valid for the stale word; next mem_addr=32'h2000.
REQ-037 redirect_pc=32'h2002 -> fetch_fault=1 and mem_req=0 until redirect to 32'h3000; then fetch at 32'h3000.
REQ-038 mem_gnt withheld 5 cycles; ir_ready low 4 cycles -> mem_addr stable throughout the wait; ir_data stable throughout the stall.
REQ-039 rst_n pulsed low in WAIT -> all outputs at reset values immediately; first request after release at RESET_PC.
